// File: rtl/mul_unit_pipe_pkg.sv
// Shared types for the pipelined multiplier: op encoding, default widths and
// the S1 payload layout at those default widths.
package mul_unit_pipe_pkg;

    localparam int MUL_XLEN  = 64;
    localparam int MUL_TAG_W = 16;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef struct packed {
        logic [MUL_XLEN-1:0]  mag1;
        logic [MUL_XLEN-1:0]  mag2;
        logic                 neg;
        mul_op_e              op;
        logic                 op32;
        logic [MUL_TAG_W-1:0] tag;
    } mul_payload_t;

endpackage

// File: rtl/mul_unit_pipe_stage.sv
// One pipeline register slice: valid bit with hold and flush, data captured
// only when a valid op moves in.
module mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         flush_i,
    input  logic         hold_i,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_o <= 1'b0;
        end else if (flush_i) begin
            vld_o <= 1'b0;
        end else if (!hold_i) begin
            vld_o <= vld_i;
        end
    end

    // Data is qualified by vld_o everywhere, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (!hold_i && vld_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/mul_unit_pipe.sv
// Pipelined MUL/MULH/MULHSU/MULHU/MULW unit with valid/ready backpressure,
// flush, tag passthrough and an in-order early exit for MULW.
module mul_unit_pipe
    import mul_unit_pipe_pkg::*;
#(
    parameter int XLEN    = MUL_XLEN,
    parameter int NSTAGES = 2,
    parameter int TAG_W   = MUL_TAG_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic             op32_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int H    = XLEN / 2;
    localparam int PP_W = XLEN + H;

    typedef struct packed {
        logic [XLEN-1:0]  mag1;
        logic [XLEN-1:0]  mag2;
        logic             neg;
        mul_op_e          op;
        logic             op32;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [PP_W-1:0]  pp_lo;
        logic [PP_W-1:0]  pp_hi;
        logic             neg;
        mul_op_e          op;
        logic             op32;
        logic [TAG_W-1:0] tag;
    } sp_t;

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v,
                                                   input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic             stall;
    logic             accept;
    logic             exit_p1;
    logic             busy_tail;
    logic [NSTAGES:1] vld_p;
    s1_t              s1_d;
    s1_t              s1_q;
    sp_t              sp_d;
    sp_t              sp_q [2:NSTAGES];
    logic [31:0]      w_prod_p1;

    assign stall  = valid_o & ~ready_i;
    assign ready_o = ~stall;
    assign accept = valid_i & ready_o;

    // Operand conditioning: signed values become magnitude plus negate flag.
    always_comb begin
        logic        sgn1, sgn2, sig1, sig2;
        logic [31:0] w1, w2;
        mul_op_e     op;
        op   = mul_op_e'(op_i);
        sig1 = op32_i || (op != OP_MULHU);
        sig2 = op32_i || (op == OP_MUL) || (op == OP_MULH);
        w1   = '0;
        w2   = '0;
        s1_d = '0;
        if (op32_i) begin
            sgn1 = rs1_i[31];
            sgn2 = rs2_i[31];
            w1   = sgn1 ? (~rs1_i[31:0] + 32'd1) : rs1_i[31:0];
            w2   = sgn2 ? (~rs2_i[31:0] + 32'd1) : rs2_i[31:0];
            s1_d.mag1 = zext32(w1);
            s1_d.mag2 = zext32(w2);
        end else begin
            sgn1 = sig1 & rs1_i[XLEN-1];
            sgn2 = sig2 & rs2_i[XLEN-1];
            s1_d.mag1 = sgn1 ? (~rs1_i + 1'b1) : rs1_i;
            s1_d.mag2 = sgn2 ? (~rs2_i + 1'b1) : rs2_i;
        end
        s1_d.neg  = sgn1 ^ sgn2;
        s1_d.op   = op;
        s1_d.op32 = op32_i;
        s1_d.tag  = tag_i;
    end

    // S1 -> S2: two half-width partial products.
    always_comb begin
        sp_d       = '0;
        sp_d.pp_lo = PP_W'(s1_q.mag1) * PP_W'(s1_q.mag2[H-1:0]);
        sp_d.pp_hi = PP_W'(s1_q.mag1) * PP_W'(s1_q.mag2[XLEN-1:H]);
        sp_d.neg   = s1_q.neg;
        sp_d.op    = s1_q.op;
        sp_d.op32  = s1_q.op32;
        sp_d.tag   = s1_q.tag;
    end

    assign busy_tail = |vld_p[NSTAGES:2];
    assign exit_p1   = vld_p[1] & s1_q.op32 & ~busy_tail;

    generate
        for (genvar g = 1; g <= NSTAGES; g++) begin : g_stage
            if (g == 1) begin : g_s1
                mul_pipe_stage #(.W($bits(s1_t))) u_stage (
                    .clk_i  (clk_i),
                    .rstn_i (rstn_i),
                    .flush_i(flush_i),
                    .hold_i (stall),
                    .vld_i  (accept),
                    .data_i (s1_d),
                    .vld_o  (vld_p[1]),
                    .data_o (s1_q)
                );
            end else if (g == 2) begin : g_s2
                // A MULW that left early must not also enter S2.
                mul_pipe_stage #(.W($bits(sp_t))) u_stage (
                    .clk_i  (clk_i),
                    .rstn_i (rstn_i),
                    .flush_i(flush_i),
                    .hold_i (stall),
                    .vld_i  (vld_p[1] & ~exit_p1),
                    .data_i (sp_d),
                    .vld_o  (vld_p[2]),
                    .data_o (sp_q[2])
                );
            end else begin : g_sn
                mul_pipe_stage #(.W($bits(sp_t))) u_stage (
                    .clk_i  (clk_i),
                    .rstn_i (rstn_i),
                    .flush_i(flush_i),
                    .hold_i (stall),
                    .vld_i  (vld_p[g-1]),
                    .data_i (sp_q[g-1]),
                    .vld_o  (vld_p[g]),
                    .data_o (sp_q[g])
                );
            end
        end
    endgenerate

    // MULW early exit only needs the low 32 product bits.
    always_comb begin
        w_prod_p1 = s1_q.mag1[31:0] * s1_q.mag2[31:0];
        if (s1_q.neg) begin
            w_prod_p1 = ~w_prod_p1 + 32'd1;
        end
    end

    // SN output: recombine partials, apply sign, select result half.
    always_comb begin
        logic [2*XLEN-1:0] prod;
        sp_t               sn;
        sn       = sp_q[NSTAGES];
        prod     = (2*XLEN)'(sn.pp_lo) + ((2*XLEN)'(sn.pp_hi) << H);
        prod     = cond_neg(prod, sn.neg);
        valid_o  = vld_p[NSTAGES] | exit_p1;
        result_o = '0;
        tag_o    = '0;
        if (vld_p[NSTAGES]) begin
            if (sn.op32) begin
                result_o = sext32(prod[31:0]);
            end else if (sn.op == OP_MUL) begin
                result_o = prod[XLEN-1:0];
            end else begin
                result_o = prod[2*XLEN-1:XLEN];
            end
            tag_o = sn.tag;
        end else if (exit_p1) begin
            result_o = sext32(w_prod_p1);
            tag_o    = s1_q.tag;
        end
    end

endmodule
